span_margin_engine: RTL and testbench



---
 rtl/span_margin_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_span_margin_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/span_margin_engine.sv
// SPAN margin engine: nine-scenario scan risk plus optional tier spread charge.
// Optional tier spread pass enabled by SPAN_MARGIN_TIER_SPREAD_EN.
module span_margin_engine #(
    parameter int N_LEGS  = 8,
    parameter int N_TIERS = 4,
    parameter int DW      = 16,
    parameter int AW      = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read,
    input  logic [AW-1:0] offset,
    input  logic [DW-1:0] writeData,
    output logic [DW-1:0] readData,
    output logic          irq
);
    localparam int MW  = 2 * DW;
    localparam int ACW = MW + $clog2(9 * N_LEGS) + 1;
    localparam int PW  = ACW + DW + 1;
    localparam int LW  = (N_LEGS > 1) ? $clog2(N_LEGS) : 1;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
    localparam int TW  = (N_TIERS > 1) ? $clog2(N_TIERS) : 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SPREAD, S_FINAL} state_e;

    state_e                 state_q, state_d;
    logic [LW-1:0]          leg_q, leg_d;
    logic [3:0]             k_q, k_d;
    logic signed [ACW-1:0]  loss_q, loss_d, max_q, max_d;
    logic [DW-1:0]          psr_q, psr_d;
    logic signed [DW-1:0]   pos_q [N_LEGS];
    logic signed [DW-1:0]   pos_d [N_LEGS];
    logic [MW-1:0]          margin_q, margin_d, scan_q, scan_d;
    logic                   done_q, done_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [DW-1:0]          rdata_q, rdata_d;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
    logic [DW-1:0]          spread_q, spread_d;
    logic [TW-1:0]          tier_q [N_LEGS];
    logic [TW-1:0]          tier_d [N_LEGS];
    logic signed [ACW-1:0]  net_q [N_TIERS];
    logic signed [ACW-1:0]  net_d [N_TIERS];
    logic [ACW-1:0]         lsum, ssum, mn;
`endif

    logic [31:0]            off;
    logic                   busy, wr, rd, start;
    logic signed [DW+3:0]   f_w, scaled, move_w;
    logic signed [ACW-1:0]  pos_w, mv_w, term, loss_sum;
    logic [ACW-1:0]         scan_u;
    logic [PW-1:0]          tsc, tot;
    logic                   scan_sat, mar_sat;

    always_comb begin
        state_d  = state_q;
        leg_d    = leg_q;
        k_d      = k_q;
        loss_d   = loss_q;
        max_d    = max_q;
        psr_d    = psr_q;
        pos_d    = pos_q;
        margin_d = margin_q;
        scan_d   = scan_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        irq_d    = 1'b0;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
        spread_d = spread_q;
        tier_d   = tier_q;
        net_d    = net_q;
`endif
        off   = 32'(offset);
        busy  = (state_q != S_IDLE);
        wr    = chipselect & write;
        rd    = chipselect & read & ~write;
        start = wr & ~busy & (off == 32'd0) & writeData[0];

        // Scenario move = floor(PSR * (k-4) / 4)
        f_w      = (DW+4)'(k_q) - (DW+4)'(4);
        scaled   = $signed({4'b0, psr_q}) * f_w;
        move_w   = scaled >>> 2;
        pos_w    = pos_q[leg_q];
        mv_w     = move_w;
        term     = -(pos_w * mv_w);
        loss_sum = loss_q + term;

`ifdef SPAN_MARGIN_TIER_SPREAD_EN
        lsum = '0;
        ssum = '0;
        for (int t = 0; t < N_TIERS; t++) begin
            if (net_q[t] > 0) lsum = lsum + ACW'(net_q[t]);
            else              ssum = ssum + ACW'(-net_q[t]);
        end
        mn  = (lsum < ssum) ? lsum : ssum;
        tsc = PW'(mn) * PW'(spread_q);
`else
        tsc = '0;
`endif
        scan_u   = max_q[ACW-1] ? '0 : ACW'(max_q);
        scan_sat = |scan_u[ACW-1:MW];
        tot      = PW'(scan_u) + tsc;
        mar_sat  = |tot[PW-1:MW];

        if (wr && !busy) begin
            if (off == 32'd2) psr_d = writeData;
            for (int i = 0; i < N_LEGS; i++)
                if (off == 32'(8 + i)) pos_d[i] = writeData;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
            if (off == 32'd3) spread_d = writeData;
            for (int i = 0; i < N_LEGS; i++)
                if (off == 32'(8 + N_LEGS + i)) tier_d[i] = writeData[TW-1:0];
`endif
        end
        if (wr && off == 32'd1 && writeData[1]) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end

        if (rd) begin
            rdata_d = '0;
            case (off)
                32'd1:   rdata_d = DW'({ovf_q, done_q, busy});
                32'd2:   rdata_d = psr_q;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
                32'd3:   rdata_d = spread_q;
`endif
                32'd4:   rdata_d = margin_q[DW-1:0];
                32'd5:   rdata_d = margin_q[MW-1:DW];
                32'd6:   rdata_d = scan_q[DW-1:0];
                32'd7:   rdata_d = scan_q[MW-1:DW];
                default: begin
                    for (int i = 0; i < N_LEGS; i++) begin
                        if (off == 32'(8 + i)) rdata_d = pos_q[i];
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
                        if (off == 32'(8 + N_LEGS + i)) rdata_d = DW'(tier_q[i]);
`endif
                    end
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    leg_d   = '0;
                    k_d     = '0;
                    loss_d  = '0;
                    max_d   = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
                    for (int t = 0; t < N_TIERS; t++) net_d[t] = '0;
`endif
                end
            end
            S_SCAN: begin
                if (leg_q == LW'(N_LEGS - 1)) begin
                    leg_d  = '0;
                    loss_d = '0;
                    max_d  = (loss_sum > max_q) ? loss_sum : max_q;
                    if (k_q == 4'd8) begin
                        k_d = '0;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
                        state_d = S_SPREAD;
`else
                        state_d = S_FINAL;
`endif
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end else begin
                    leg_d  = leg_q + LW'(1);
                    loss_d = loss_sum;
                end
            end
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
            S_SPREAD: begin
                // Out-of-range tiers match no net and are skipped
                for (int t = 0; t < N_TIERS; t++)
                    if (32'(tier_q[leg_q]) == 32'(t)) net_d[t] = net_q[t] + pos_w;
                if (leg_q == LW'(N_LEGS - 1)) begin
                    leg_d   = '0;
                    state_d = S_FINAL;
                end else begin
                    leg_d = leg_q + LW'(1);
                end
            end
`endif
            S_FINAL: begin
                scan_d   = scan_sat ? {MW{1'b1}} : scan_u[MW-1:0];
                margin_d = mar_sat ? {MW{1'b1}} : tot[MW-1:0];
                ovf_d    = scan_sat | mar_sat;
                done_d   = 1'b1;
                irq_d    = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            leg_q    <= '0;
            k_q      <= '0;
            loss_q   <= '0;
            max_q    <= '0;
            psr_q    <= '0;
            for (int i = 0; i < N_LEGS; i++) pos_q[i] <= '0;
            margin_q <= '0;
            scan_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
            spread_q <= '0;
            for (int i = 0; i < N_LEGS; i++) tier_q[i] <= '0;
            for (int t = 0; t < N_TIERS; t++) net_q[t] <= '0;
`endif
        end else begin
            state_q  <= state_d;
            leg_q    <= leg_d;
            k_q      <= k_d;
            loss_q   <= loss_d;
            max_q    <= max_d;
            psr_q    <= psr_d;
            pos_q    <= pos_d;
            margin_q <= margin_d;
            scan_q   <= scan_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
            spread_q <= spread_d;
            tier_q   <= tier_d;
            net_q    <= net_d;
`endif
        end
    end

    assign readData = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_span_margin_engine.sv
// Bench for span_margin_engine: directed table, random vs reference model,
// and hand sequences for busy, reset and status corner cases.
module tb_span_margin_engine;
    localparam int NL = 8;
`ifdef SPAN_MARGIN_TIER_SPREAD_EN
    localparam int  LAT = 10 * NL + 1;
    localparam bit  SPR = 1'b1;
`else
    localparam int  LAT = 9 * NL + 1;
    localparam bit  SPR = 1'b0;
`endif
    localparam longint MAXM = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect, write, read;
    logic [5:0]  offset;
    logic [15:0] writeData, readData;
    logic        irq;

    int nvec = 0;
    int nerr = 0;

    span_margin_engine #(.N_LEGS(NL), .N_TIERS(4), .DW(16), .AW(6)) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect),
        .write(write), .read(read), .offset(offset),
        .writeData(writeData), .readData(readData), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0][15:0] pos;
        logic [NL-1:0][1:0]  tr;
        logic [15:0]         psr;
        logic [15:0]         sc;
        longint              scan;
        longint              m_en;
        longint              m_dis;
        bit                  ovf;
    } vec_t;

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input int o, input logic [15:0] d);
        chipselect = 1'b1; write = 1'b1; offset = 6'(o); writeData = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input int o, output logic [15:0] d);
        chipselect = 1'b1; read = 1'b1; offset = 6'(o);
        @(posedge clk); #1;
        d = readData;
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Reference: direct evaluation of scenario losses and tier nets
    function automatic void model(input logic [NL-1:0][15:0] pos,
                                  input logic [NL-1:0][1:0] tr,
                                  input int unsigned psr, input int unsigned sc,
                                  output longint scan, output longint mar,
                                  output bit ovf);
        longint mx, loss, p, mv, tsc, l, s;
        longint net[4];
        mx = 0;
        for (int k = 0; k < 9; k++) begin
            p  = longint'(psr) * longint'(k - 4);
            mv = (p >= 0) ? p / 4 : -((-p + 3) / 4);
            loss = 0;
            for (int i = 0; i < NL; i++)
                loss += -(longint'($signed(pos[i])) * mv);
            if (loss > mx) mx = loss;
        end
        tsc = 0;
        if (SPR) begin
            for (int t = 0; t < 4; t++) net[t] = 0;
            for (int i = 0; i < NL; i++) net[tr[i]] += longint'($signed(pos[i]));
            l = 0; s = 0;
            for (int t = 0; t < 4; t++)
                if (net[t] > 0) l += net[t]; else s += -net[t];
            tsc = ((l < s) ? l : s) * longint'(sc);
        end
        ovf  = 1'b0;
        scan = mx;
        mar  = mx + tsc;
        if (scan > MAXM) begin scan = MAXM; ovf = 1'b1; end
        if (mar > MAXM) begin mar = MAXM; ovf = 1'b1; end
    endfunction

    task automatic load(input logic [NL-1:0][15:0] pos, input logic [NL-1:0][1:0] tr,
                        input logic [15:0] psr, input logic [15:0] sc);
        bus_write(2, psr);
        bus_write(3, sc);
        for (int i = 0; i < NL; i++) begin
            bus_write(8 + i, pos[i]);
            bus_write(8 + NL + i, {14'b0, tr[i]});
        end
    endtask

    task automatic wait_done(input string nm, input int c0);
        int cnt;
        cnt = c0;
        while (1) begin
            @(posedge clk); #1;
            cnt++;
            if (irq || cnt > 400) break;
        end
        check({nm, " latency"}, cnt, LAT);
        @(posedge clk); #1;
        check({nm, " irq pulse"}, irq, 0);
    endtask

    task automatic check_results(input string nm, input longint es, input longint em,
                                 input bit eo);
        logic [15:0] lo, hi, st;
        bus_read(6, lo); bus_read(7, hi);
        check({nm, " scan"}, {hi, lo}, es);
        bus_read(4, lo); bus_read(5, hi);
        check({nm, " margin"}, {hi, lo}, em);
        bus_read(1, st);
        check({nm, " status"}, st, {eo, 2'b10});
    endtask

    task automatic run_case(input string nm, input logic [NL-1:0][15:0] pos,
                            input logic [NL-1:0][1:0] tr, input logic [15:0] psr,
                            input logic [15:0] sc, input longint es,
                            input longint em, input bit eo);
        logic [15:0] d;
        load(pos, tr, psr, sc);
        bus_write(0, 16'h1);
        bus_read(1, d);
        check({nm, " busy"}, d[0], 1);
        wait_done(nm, 1);
        check_results(nm, es, em, eo);
    endtask

    vec_t tbl[5];

    initial begin
        logic [15:0] d, d0;
        logic [NL-1:0][15:0] rp;
        logic [NL-1:0][1:0]  rt;
        logic [15:0] rpsr, rsc;
        longint es, em;
        bit eo;

        chipselect = 0; write = 0; read = 0; offset = '0; writeData = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check("reset irq", irq, 0);
        for (int o = 0; o < 64; o++) begin
            bus_read(o, d);
            check($sformatf("reset rd%0d", o), d, 0);
        end

        for (int i = 0; i < 5; i++) begin
            tbl[i].pos = '0; tbl[i].tr = '0; tbl[i].sc = '0; tbl[i].ovf = 1'b0;
        end
        tbl[0].psr = 400; tbl[0].pos[0] = 16'd10;
        tbl[0].scan = 4000; tbl[0].m_en = 4000; tbl[0].m_dis = 4000;
        tbl[1].psr = 400; tbl[1].sc = 25;
        tbl[1].pos[0] = 16'd10; tbl[1].pos[1] = -16'sd6; tbl[1].tr[1] = 2'd1;
        tbl[1].scan = 1600; tbl[1].m_en = 1750; tbl[1].m_dis = 1600;
        tbl[2].psr = 100; tbl[2].pos[0] = -16'sd20;
        tbl[2].scan = 2000; tbl[2].m_en = 2000; tbl[2].m_dis = 2000;
        tbl[3].psr = 8; tbl[3].sc = 10;
        tbl[3].pos[0] = 16'd5;     tbl[3].tr[0] = 2'd0;
        tbl[3].pos[1] = 16'd7;     tbl[3].tr[1] = 2'd2;
        tbl[3].pos[2] = -16'sd9;   tbl[3].tr[2] = 2'd3;
        tbl[3].pos[3] = -16'sd1;   tbl[3].tr[3] = 2'd1;
        tbl[3].scan = 16; tbl[3].m_en = 116; tbl[3].m_dis = 16;
        tbl[4].psr = 16'hFFFF;
        for (int i = 0; i < NL; i++) tbl[4].pos[i] = 16'h7FFF;
        tbl[4].scan = MAXM; tbl[4].m_en = MAXM; tbl[4].m_dis = MAXM; tbl[4].ovf = 1'b1;

        for (int i = 0; i < 5; i++)
            run_case($sformatf("tbl%0d", i), tbl[i].pos, tbl[i].tr, tbl[i].psr,
                     tbl[i].sc, tbl[i].scan, SPR ? tbl[i].m_en : tbl[i].m_dis,
                     tbl[i].ovf);

        bus_write(1, 16'h2);
        bus_read(1, d);
        check("status clear", d, 0);

        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 3) == 0) rp[i] = 16'($urandom);
                else rp[i] = 16'($urandom_range(0, 1000)) - 16'd500;
                rt[i] = 2'($urandom_range(0, 3));
            end
            rpsr = 16'($urandom);
            rsc  = 16'($urandom_range(0, 255));
            model(rp, rt, rpsr, rsc, es, em, eo);
            run_case($sformatf("rnd%0d", n), rp, rt, rpsr, rsc, es, em, eo);
        end

        // Writes and a second start while busy must be ignored
        load(tbl[0].pos, tbl[0].tr, tbl[0].psr, tbl[0].sc);
        bus_write(0, 16'h1);
        bus_write(8, 16'd1000);
        bus_write(0, 16'h1);
        wait_done("busy ign", 2);
        check_results("busy ign", 4000, 4000, 1'b0);
        bus_read(8, d);
        check("busy ign pos0", d, 10);

        // Status clear landing on the FINAL edge loses to FINAL
        bus_write(0, 16'h1);
        repeat (LAT - 1) @(posedge clk);
        #1;
        bus_write(1, 16'h2);
        bus_read(1, d);
        check("clr at final", d, 16'h2);

        // Read and write together: write lands, readData holds
        bus_read(2, d0);
        chipselect = 1; write = 1; read = 1; offset = 6'd2; writeData = 16'd123;
        @(posedge clk); #1;
        check("rw hold", readData, d0);
        chipselect = 0; write = 0; read = 0;
        bus_read(2, d);
        check("rw write", d, 123);

        // Reset mid-scan
        load(tbl[1].pos, tbl[1].tr, tbl[1].psr, tbl[1].sc);
        bus_read(2, d);
        bus_write(0, 16'h1);
        repeat (20) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst rdata", readData, 0);
        check("rst irq", irq, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        bus_read(1, d); check("rst status", d, 0);
        bus_read(4, d); check("rst margin", d, 0);
        bus_read(2, d); check("rst psr", d, 0);
        bus_read(8, d); check("rst pos0", d, 0);
        repeat (LAT) @(posedge clk);
        #1 check("rst no irq", irq, 0);
        run_case("after rst", tbl[1].pos, tbl[1].tr, tbl[1].psr, tbl[1].sc,
                 tbl[1].scan, SPR ? tbl[1].m_en : tbl[1].m_dis, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
